// File: rtl/card_shoe.sv
// card_shoe: multi-deck card shoe with per-rank counts and a forward-probing dealer.
// A request picks a start rank (free-running selector or LFSR), then probes
// forward one rank per cycle until it finds a rank with cards left.
module card_shoe #(
  parameter int          DECKS  = 1,
  parameter int          CUT    = 0,
  parameter int          RANDOM = 0,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         CW     = $clog2(52*DECKS+1)
) (
  input  logic          slow_clock,
  input  logic          reset,
  input  logic          shuffle,
  input  logic          deal_req,
  output logic [3:0]    card,
  output logic          card_valid,
  output logic          busy,
  output logic          shoe_empty,
  output logic          cut_reached,
  output logic [CW-1:0] remaining
);

  localparam int NW = $clog2(4*DECKS+1);
  localparam logic [NW-1:0] RANK_FULL = NW'(4*DECKS);
  localparam logic [CW-1:0] SHOE_FULL = CW'(52*DECKS);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_FILL} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_sel;
  logic [15:0]     r_lfsr;
  logic [3:0]      r_probe;
  logic [3:0]      r_card;
  logic            r_card_valid;
  logic [CW-1:0]   r_remaining;
  logic [NW-1:0]   r_count [13];

  logic [3:0]      w_start_rank;
  logic [3:0]      w_idx;
  logic [NW-1:0]   w_cur_count;
  logic            w_lfsr_fb;
  logic            w_start;
  logic            w_take;
  logic            w_step;
  logic            w_fill;

  // Start-rank source chosen at elaboration time.
  generate
    if (RANDOM != 0) begin : g_lfsr_start
      assign w_start_rank = 4'(r_lfsr % 16'd13) + 4'd1;
    end else begin : g_sel_start
      assign w_start_rank = r_sel;
    end
  endgenerate

  assign w_idx       = r_probe - 4'd1;
  assign w_cur_count = r_count[w_idx];
  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  assign card        = r_card;
  assign card_valid  = r_card_valid;
  assign remaining   = r_remaining;
  assign busy        = (r_state != S_IDLE);
  assign shoe_empty  = (r_remaining == '0);
  assign cut_reached = (r_remaining <= CW'(CUT));

  // Free-running rank selector and LFSR, both advance on every edge.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_sel  <= 4'd1;
      r_lfsr <= SEED;
    end else begin
      r_sel  <= (r_sel == 4'd13) ? 4'd1 : r_sel + 4'd1;
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // State register.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath controls; shuffle always wins over a deal.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take       = 1'b0;
    w_step       = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (shuffle) begin
          w_state_next = S_FILL;
        end else if (deal_req && (r_remaining != '0)) begin
          w_start      = 1'b1;
          w_state_next = S_PROBE;
        end
      end
      S_PROBE: begin
        if (shuffle) begin
          w_state_next = S_FILL;
        end else if (w_cur_count != '0) begin
          w_take       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_step       = 1'b1;
        end
      end
      S_FILL: begin
        w_fill       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shoe contents, probe pointer and dealt-card outputs.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_probe      <= 4'd1;
      r_card       <= 4'd0;
      r_card_valid <= 1'b0;
      r_remaining  <= SHOE_FULL;
      for (int i = 0; i < 13; i++) r_count[i] <= RANK_FULL;
    end else begin
      r_card_valid <= w_take;
      if (w_fill) begin
        r_card      <= 4'd0;
        r_remaining <= SHOE_FULL;
        for (int i = 0; i < 13; i++) r_count[i] <= RANK_FULL;
      end else if (w_take) begin
        r_count[w_idx] <= w_cur_count - 1'b1;
        r_remaining    <= r_remaining - 1'b1;
        r_card         <= r_probe;
      end
      if (w_start) begin
        r_probe <= w_start_rank;
      end else if (w_step) begin
        r_probe <= (r_probe == 4'd13) ? 4'd1 : r_probe + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: three instances (1 deck, 2 decks with cut at 10, 1 deck
// with LFSR start) share clock and reset; a rank-count model predicts every deal.
module tb_card_shoe;

  logic       clk;
  logic       rst;
  logic       shuffle_r [3];
  logic       deal_r    [3];
  logic [3:0] card_w    [3];
  logic       valid_w   [3];
  logic       busy_w    [3];
  logic       empty_w   [3];
  logic       cut_w     [3];
  logic [5:0] rem0;
  logic [6:0] rem1;
  logic [5:0] rem2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_no  = 0;
  int unsigned m_lfsr   = 32'hACE1;
  int          m_cnt  [3][13];
  int          tally  [3][13];
  int          m_rem  [3];
  int          decks  [3] = '{1, 2, 1};
  int          cuts   [3] = '{0, 10, 0};

  card_shoe #(.DECKS(1), .CUT(0), .RANDOM(0)) u_dut0 (
    .slow_clock(clk), .reset(rst), .shuffle(shuffle_r[0]), .deal_req(deal_r[0]),
    .card(card_w[0]), .card_valid(valid_w[0]), .busy(busy_w[0]),
    .shoe_empty(empty_w[0]), .cut_reached(cut_w[0]), .remaining(rem0));

  card_shoe #(.DECKS(2), .CUT(10), .RANDOM(0)) u_dut1 (
    .slow_clock(clk), .reset(rst), .shuffle(shuffle_r[1]), .deal_req(deal_r[1]),
    .card(card_w[1]), .card_valid(valid_w[1]), .busy(busy_w[1]),
    .shoe_empty(empty_w[1]), .cut_reached(cut_w[1]), .remaining(rem1));

  card_shoe #(.DECKS(1), .CUT(0), .RANDOM(1), .SEED(16'hACE1)) u_dut2 (
    .slow_clock(clk), .reset(rst), .shuffle(shuffle_r[2]), .deal_req(deal_r[2]),
    .card(card_w[2]), .card_valid(valid_w[2]), .busy(busy_w[2]),
    .shoe_empty(empty_w[2]), .cut_reached(cut_w[2]), .remaining(rem2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rem_of(input int d);
    case (d)
      0:       rem_of = {26'd0, rem0};
      1:       rem_of = {25'd0, rem1};
      default: rem_of = {26'd0, rem2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_full(input int d);
    m_rem[d] = 52 * decks[d];
    for (int r = 0; r < 13; r++) begin
      m_cnt[d][r] = 4 * decks[d];
      tally[d][r] = 0;
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    int unsigned b;
    @(posedge clk);
    #1;
    edge_no++;
    b = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (b << 15);
  endtask

  task automatic check_shoe(input int d);
    check("remaining", rem_of(d), m_rem[d]);
    check("shoe_empty", empty_w[d], (m_rem[d] == 0) ? 1 : 0);
    check("cut_reached", cut_w[d], (m_rem[d] <= cuts[d]) ? 1 : 0);
  endtask

  // Asserts reset between edges and checks outputs before any edge arrives.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      model_full(d);
      check("rst_card", card_w[d], 0);
      check("rst_valid", valid_w[d], 0);
      check("rst_busy", busy_w[d], 0);
      check_shoe(d);
    end
    #1;
    rst = 1'b0;
    edge_no = 0;
    m_lfsr = 32'hACE1;
  endtask

  task automatic wait_sel(input int r);
    while ((edge_no % 13) + 1 != r) tick();
  endtask

  // One deal request; predicts card and latency from the rank counts.
  task automatic do_deal(input int d, output int got, output int lat);
    int start;
    int r;
    int n;
    logic seen;
    start = (d == 2) ? int'(m_lfsr % 13) + 1 : (edge_no % 13) + 1;
    deal_r[d] = 1'b1;
    tick();
    deal_r[d] = 1'b0;
    got = 0;
    lat = 1;
    if (m_rem[d] == 0) begin
      check("empty_busy", busy_w[d], 0);
      check("empty_valid", valid_w[d], 0);
      tick();
      check("empty_valid2", valid_w[d], 0);
      check("empty_busy2", busy_w[d], 0);
      $display("deal dut%0d: start %0d ignored, shoe empty", d, start);
      return;
    end
    r = start;
    n = 0;
    while (m_cnt[d][r-1] == 0) begin
      r = (r == 13) ? 1 : r + 1;
      n++;
    end
    seen = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      lat++;
      if (valid_w[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check("probe_busy", busy_w[d], 1);
    end
    if (!seen) begin
      check("deal_timeout", 0, 1);
      return;
    end
    got = card_w[d];
    m_cnt[d][r-1]--;
    m_rem[d]--;
    tally[d][r-1]++;
    check("card", card_w[d], r);
    check("latency", lat, 2 + n);
    check("done_busy", busy_w[d], 0);
    check_shoe(d);
    $display("deal dut%0d: start %0d card %0d latency %0d remaining %0d",
             d, start, got, lat, rem_of(d));
  endtask

  initial begin
    int got;
    int lat;
    int gaps [52];
    int seq1 [52];

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      shuffle_r[d] = 1'b0;
      deal_r[d]    = 1'b0;
    end
    #2;
    apply_reset();

    // First edge after reset: selector is 1, so an Ace after two edges.
    do_deal(0, got, lat);
    check("basic_card", got, 1);
    check("basic_lat", lat, 2);
    tick();
    check("valid_pulse", valid_w[0], 0);

    // Remaining Aces, then a request starting at rank 1 must skip to 2.
    for (int i = 0; i < 3; i++) begin
      wait_sel(1);
      do_deal(0, got, lat);
      check("ace_card", got, 1);
    end
    wait_sel(1);
    do_deal(0, got, lat);
    check("skip_card", got, 2);
    check("skip_lat", lat, 3);

    // Empty ranks 2..12, then a probe from rank 1 walks all the way to King.
    for (int r = 2; r <= 12; r++) begin
      while (m_cnt[0][r-1] > 0) begin
        wait_sel(r);
        do_deal(0, got, lat);
      end
    end
    wait_sel(1);
    do_deal(0, got, lat);
    check("king_card", got, 13);
    check("king_lat", lat, 14);

    // Drain the shoe with random gaps, then an ignored request on empty.
    while (m_rem[0] > 0) begin
      repeat ($urandom_range(0, 4)) tick();
      do_deal(0, got, lat);
    end
    for (int r = 0; r < 13; r++) check("tally_dut0", tally[0][r], 4);
    check("exhaust_empty", empty_w[0], 1);
    do_deal(0, got, lat);

    // Two-deck shoe: cut card crosses exactly on the 94th deal.
    for (int i = 1; i <= 94; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_deal(1, got, lat);
      if (i == 93) check("cut_before", cut_w[1], 0);
    end
    check("cut_after", cut_w[1], 1);
    check("cut_rem", rem1, 10);
    check("cut_not_empty", empty_w[1], 0);

    // Shuffle during PROBE aborts the deal and refills.
    deal_r[1] = 1'b1;
    tick();
    deal_r[1] = 1'b0;
    check("abort_in_probe", busy_w[1], 1);
    shuffle_r[1] = 1'b1;
    tick();
    shuffle_r[1] = 1'b0;
    check("abort_valid", valid_w[1], 0);
    check("abort_fill_busy", busy_w[1], 1);
    tick();
    model_full(1);
    check("abort_valid2", valid_w[1], 0);
    check("abort_idle", busy_w[1], 0);
    check("abort_card", card_w[1], 0);
    check_shoe(1);

    // Shuffle and deal on the same IDLE edge: fill only.
    shuffle_r[1] = 1'b1;
    deal_r[1]    = 1'b1;
    tick();
    shuffle_r[1] = 1'b0;
    deal_r[1]    = 1'b0;
    check("both_fill_busy", busy_w[1], 1);
    check("both_valid", valid_w[1], 0);
    tick();
    check("both_idle", busy_w[1], 0);
    check("both_valid2", valid_w[1], 0);
    check_shoe(1);

    // Held shuffle alternates FILL and IDLE.
    shuffle_r[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_shuffle_busy", busy_w[1], (i % 2 == 0) ? 1 : 0);
    end
    shuffle_r[1] = 1'b0;
    check_shoe(1);

    // Async reset while a deal is in PROBE.
    do_deal(1, got, lat);
    deal_r[1] = 1'b1;
    tick();
    deal_r[1] = 1'b0;
    check("pre_reset_probe", busy_w[1], 1);
    apply_reset();

    // LFSR start rank: same sequence across two runs, full deck dealt.
    for (int i = 0; i < 52; i++) gaps[i] = $urandom_range(0, 5);
    for (int i = 0; i < 52; i++) begin
      repeat (gaps[i]) tick();
      do_deal(2, got, lat);
      seq1[i] = got;
    end
    for (int r = 0; r < 13; r++) check("tally_dut2", tally[2][r], 4);
    check("rand_empty", empty_w[2], 1);
    tick();
    apply_reset();
    for (int i = 0; i < 52; i++) begin
      repeat (gaps[i]) tick();
      do_deal(2, got, lat);
      check("repeat_seq", got, seq1[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
